// File: rtl/apb4_pkg.sv
// Shared types for the APB4 requester: transfer state encoding and pprot bit positions.
package apb4_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2,
    RESP   = 2'd3
  } apb4_mst_state_t;

  localparam int PPROT_PRIV   = 0;
  localparam int PPROT_NONSEC = 1;
  localparam int PPROT_INSTR  = 2;

endpackage

// File: rtl/apb4_master_timer.sv
// ACCESS-phase watchdog: counts enabled cycles since the last clear and flags the
// last permitted cycle. A TIMEOUT_CYCLES of 0 leaves expired permanently low.
module apb4_master_timer #(
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int CW     = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam int LAST_I = (TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0;
  localparam logic [CW-1:0] SAT  = TIMEOUT_CYCLES[CW-1:0];
  localparam logic [CW-1:0] LAST = LAST_I[CW-1:0];

  logic [CW-1:0] count_q;
  logic [CW-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (clear) begin
      count_d = '0;
    end else if (enable && (count_q != SAT)) begin
      count_d = count_q + CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  // count_q holds the ACCESS cycles already spent, so the current one is the last allowed at T-1
  assign expired = (TIMEOUT_CYCLES != 0) && enable && (count_q >= LAST);

endmodule

// File: rtl/apb4_master.sv
// APB4 requester: takes one command over valid/ready, runs a SETUP/ACCESS transfer
// and returns read data plus error/timeout status over a valid/ready response port.
module apb4_master
  import apb4_pkg::*;
#(
  parameter int ADDR_WIDTH     = 32,
  parameter int DATA_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    cmd_valid,
  output logic                    cmd_ready,
  input  logic                    cmd_write,
  input  logic [ADDR_WIDTH-1:0]   cmd_addr,
  input  logic [DATA_WIDTH-1:0]   cmd_wdata,
  input  logic [DATA_WIDTH/8-1:0] cmd_strb,
  input  logic [2:0]              cmd_prot,
  output logic                    rsp_valid,
  input  logic                    rsp_ready,
  output logic [DATA_WIDTH-1:0]   rsp_rdata,
  output logic                    rsp_err,
  output logic                    rsp_timeout,
  output logic                    psel,
  output logic                    penable,
  output logic                    pwrite,
  output logic [ADDR_WIDTH-1:0]   paddr,
  output logic [DATA_WIDTH-1:0]   pwdata,
  output logic [DATA_WIDTH/8-1:0] pstrb,
  output logic [2:0]              pprot,
  input  logic                    pready,
  input  logic                    pslverr,
  input  logic [DATA_WIDTH-1:0]   prdata
);

  apb4_mst_state_t state_q, state_d;

  logic                    psel_q, psel_d;
  logic                    penable_q, penable_d;
  logic                    pwrite_q, pwrite_d;
  logic [ADDR_WIDTH-1:0]   paddr_q, paddr_d;
  logic [DATA_WIDTH-1:0]   pwdata_q, pwdata_d;
  logic [DATA_WIDTH/8-1:0] pstrb_q, pstrb_d;
  logic [2:0]              pprot_q, pprot_d;
  logic                    rsp_valid_q, rsp_valid_d;
  logic [DATA_WIDTH-1:0]   rsp_rdata_q, rsp_rdata_d;
  logic                    rsp_err_q, rsp_err_d;
  logic                    rsp_timeout_q, rsp_timeout_d;
  logic                    tmo_expired;

  apb4_master_timer #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timer (
    .clk    (clk),
    .rst    (rst),
    .clear  (state_q == SETUP),
    .enable (state_q == ACCESS),
    .expired(tmo_expired)
  );

  always_comb begin
    state_d       = state_q;
    psel_d        = psel_q;
    penable_d     = penable_q;
    pwrite_d      = pwrite_q;
    paddr_d       = paddr_q;
    pwdata_d      = pwdata_q;
    pstrb_d       = pstrb_q;
    pprot_d       = pprot_q;
    rsp_valid_d   = rsp_valid_q;
    rsp_rdata_d   = rsp_rdata_q;
    rsp_err_d     = rsp_err_q;
    rsp_timeout_d = rsp_timeout_q;
    unique case (state_q)
      IDLE: begin
        if (cmd_valid) begin
          state_d   = SETUP;
          psel_d    = 1'b1;
          penable_d = 1'b0;
          pwrite_d  = cmd_write;
          paddr_d   = cmd_addr;
          pwdata_d  = cmd_write ? cmd_wdata : '0;
          pstrb_d   = cmd_write ? cmd_strb : '0;
          pprot_d   = cmd_prot;
        end
      end
      SETUP: begin
        state_d   = ACCESS;
        penable_d = 1'b1;
      end
      ACCESS: begin
        // a completion on the expiry cycle takes priority over the abort
        if (pready) begin
          state_d       = RESP;
          psel_d        = 1'b0;
          penable_d     = 1'b0;
          rsp_valid_d   = 1'b1;
          rsp_rdata_d   = pwrite_q ? '0 : prdata;
          rsp_err_d     = pslverr;
          rsp_timeout_d = 1'b0;
        end else if (tmo_expired) begin
          state_d       = RESP;
          psel_d        = 1'b0;
          penable_d     = 1'b0;
          rsp_valid_d   = 1'b1;
          rsp_rdata_d   = '0;
          rsp_err_d     = 1'b1;
          rsp_timeout_d = 1'b1;
        end
      end
      RESP: begin
        if (rsp_ready) begin
          state_d     = IDLE;
          rsp_valid_d = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= IDLE;
      psel_q        <= 1'b0;
      penable_q     <= 1'b0;
      pwrite_q      <= 1'b0;
      paddr_q       <= '0;
      pwdata_q      <= '0;
      pstrb_q       <= '0;
      pprot_q       <= '0;
      rsp_valid_q   <= 1'b0;
      rsp_rdata_q   <= '0;
      rsp_err_q     <= 1'b0;
      rsp_timeout_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      psel_q        <= psel_d;
      penable_q     <= penable_d;
      pwrite_q      <= pwrite_d;
      paddr_q       <= paddr_d;
      pwdata_q      <= pwdata_d;
      pstrb_q       <= pstrb_d;
      pprot_q       <= pprot_d;
      rsp_valid_q   <= rsp_valid_d;
      rsp_rdata_q   <= rsp_rdata_d;
      rsp_err_q     <= rsp_err_d;
      rsp_timeout_q <= rsp_timeout_d;
    end
  end

  // held low while rst is asserted so every output reads 0 during reset
  assign cmd_ready   = (state_q == IDLE) && !rst;
  assign psel        = psel_q;
  assign penable     = penable_q;
  assign pwrite      = pwrite_q;
  assign paddr       = paddr_q;
  assign pwdata      = pwdata_q;
  assign pstrb       = pstrb_q;
  assign pprot       = pprot_q;
  assign rsp_valid   = rsp_valid_q;
  assign rsp_rdata   = rsp_rdata_q;
  assign rsp_err     = rsp_err_q;
  assign rsp_timeout = rsp_timeout_q;

endmodule

// File: tb/tb_apb4_master.sv
// Randomized bench for apb4_master: a cycle-window model derived from accept time, wait
// states and response backpressure predicts every output on every cycle.
module tb_apb4_master;
  import apb4_pkg::*;

  localparam int AW  = 32;
  localparam int DW  = 32;
  localparam int SW  = DW / 8;
  localparam int TMO = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          cmd_valid = 1'b0, cmd_ready, cmd_write = 1'b0;
  logic [AW-1:0] cmd_addr = '0;
  logic [DW-1:0] cmd_wdata = '0;
  logic [SW-1:0] cmd_strb = '0;
  logic [2:0]    cmd_prot = '0;
  logic          rsp_valid, rsp_ready = 1'b0;
  logic [DW-1:0] rsp_rdata;
  logic          rsp_err, rsp_timeout;
  logic          psel, penable, pwrite;
  logic [AW-1:0] paddr;
  logic [DW-1:0] pwdata;
  logic [SW-1:0] pstrb;
  logic [2:0]    pprot;
  logic          pready = 1'b0, pslverr = 1'b0;
  logic [DW-1:0] prdata = '0;

  apb4_master #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT_CYCLES(TMO)) dut (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_write(cmd_write), .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
    .cmd_strb(cmd_strb), .cmd_prot(cmd_prot), .rsp_valid(rsp_valid),
    .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .rsp_timeout(rsp_timeout), .psel(psel), .penable(penable), .pwrite(pwrite),
    .paddr(paddr), .pwdata(pwdata), .pstrb(pstrb), .pprot(pprot),
    .pready(pready), .pslverr(pslverr), .prdata(prdata)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_vec = 0;
  int n_bad = 0;
  bit chk_en = 1'b0;

  // current transaction as the model sees it
  int            t_a = -100, t_e = 0, t_b = 0;
  logic          t_write = 1'b0;
  logic [AW-1:0] t_addr = '0;
  logic [DW-1:0] t_wdata = '0, t_rdata_exp = '0;
  logic [SW-1:0] t_strb = '0;
  logic [2:0]    t_prot = '0;
  logic          t_err_exp = 1'b0, t_tmo_exp = 1'b0;

  // per-transaction observations for literal checks
  int            obs_psel_first, obs_pen_first, obs_rsp_first, obs_psel_drop, obs_rsp_cycles;
  logic [DW-1:0] obs_rdata;
  logic          obs_err, obs_tmo, obs_cr_busy;
  logic [SW-1:0] obs_pstrb;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      int  c;
      bit  sel, en, rv, busy;
      c    = cyc;
      sel  = (c >= t_a + 1) && (c <= t_a + 2 + t_e);
      en   = (c >= t_a + 2) && (c <= t_a + 2 + t_e);
      rv   = (c >= t_a + 3 + t_e) && (c <= t_a + 3 + t_e + t_b);
      busy = (c >= t_a + 1) && (c <= t_a + 3 + t_e + t_b);
      check("cmd_ready", 32'(cmd_ready), 32'(!busy));
      check("psel", 32'(psel), 32'(sel));
      check("penable", 32'(penable), 32'(en));
      check("rsp_valid", 32'(rsp_valid), 32'(rv));
      if (sel) begin
        check("pwrite", 32'(pwrite), 32'(t_write));
        check("paddr", paddr, t_addr);
        check("pwdata", pwdata, t_write ? t_wdata : 32'h0);
        check("pstrb", 32'(pstrb), t_write ? 32'(t_strb) : 32'h0);
        check("pprot", 32'(pprot), 32'(t_prot));
      end
      if (rv) begin
        check("rsp_rdata", rsp_rdata, t_rdata_exp);
        check("rsp_err", 32'(rsp_err), 32'(t_err_exp));
        check("rsp_timeout", 32'(rsp_timeout), 32'(t_tmo_exp));
      end
    end
  end

  task automatic observe(input int rel);
    if (psel && obs_psel_first < 0) obs_psel_first = rel;
    if (penable && obs_pen_first < 0) obs_pen_first = rel;
    if (rel == 1) obs_pstrb = pstrb;
    if (rel > 1 && !psel && obs_psel_first >= 0 && obs_psel_drop < 0) obs_psel_drop = rel;
    if (rel > 0 && cmd_ready) obs_cr_busy = 1'b1;
    if (rsp_valid) begin
      obs_rsp_cycles++;
      if (obs_rsp_first < 0) begin
        obs_rsp_first = rel;
        obs_rdata     = rsp_rdata;
        obs_err       = rsp_err;
        obs_tmo       = rsp_timeout;
      end
    end
  endtask

  // w = ACCESS wait cycles before pready (w >= TMO means pready never comes), b = rsp_ready delay
  task automatic run_txn(input logic wr, input logic [AW-1:0] addr, input logic [DW-1:0] wd,
                         input logic [SW-1:0] st, input logic [2:0] pr, input int gap,
                         input int w, input logic serr, input logic [DW-1:0] rd,
                         input int b, input bit hold);
    int a, e, last;
    bit tmo;
    tmo = (w >= TMO);
    e   = tmo ? TMO - 1 : w;
    for (int i = 0; i < gap; i++) begin
      @(posedge clk); #1;
      cmd_valid = 1'b0;
      pready    = 1'($urandom);
      pslverr   = 1'($urandom);
      rsp_ready = 1'($urandom);
    end
    @(posedge clk); #1;
    a = cyc;
    t_a = a; t_e = e; t_b = b;
    t_write = wr; t_addr = addr; t_wdata = wd; t_strb = st; t_prot = pr;
    t_rdata_exp = (tmo || wr) ? '0 : rd;
    t_err_exp   = tmo ? 1'b1 : serr;
    t_tmo_exp   = tmo;
    obs_psel_first = -1; obs_pen_first = -1; obs_rsp_first = -1; obs_psel_drop = -1;
    obs_rsp_cycles = 0; obs_cr_busy = 1'b0; obs_rdata = '0; obs_err = 1'b0; obs_tmo = 1'b0;
    obs_pstrb = '0;
    last = a + 3 + e + b;
    for (int c = a; c <= last; c++) begin
      if (c != a) begin
        @(posedge clk); #1;
      end
      observe(c - a);
      if (c == a) begin
        cmd_valid = 1'b1; cmd_write = wr; cmd_addr = addr; cmd_wdata = wd;
        cmd_strb = st; cmd_prot = pr;
      end else begin
        cmd_valid = hold ? 1'b1 : 1'($urandom);
        cmd_write = 1'($urandom); cmd_addr = $urandom; cmd_wdata = $urandom;
        cmd_strb = SW'($urandom); cmd_prot = 3'($urandom);
      end
      if (c >= a + 2 && c <= a + 2 + e) begin
        pready  = !tmo && (c == a + 2 + w);
        pslverr = pready ? serr : 1'b1;
      end else begin
        pready  = 1'($urandom);
        pslverr = 1'($urandom);
      end
      prdata    = (!tmo && c == a + 2 + w) ? rd : $urandom;
      rsp_ready = (c < a + 3 + e) ? 1'($urandom) : (c == last);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected $finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [2:0] pr_rst;
    // reset state with rst held
    repeat (3) @(posedge clk);
    #1;
    check("rst_psel", 32'(psel), 0);
    check("rst_penable", 32'(penable), 0);
    check("rst_pwrite", 32'(pwrite), 0);
    check("rst_paddr", paddr, 0);
    check("rst_pwdata", pwdata, 0);
    check("rst_pstrb", 32'(pstrb), 0);
    check("rst_pprot", 32'(pprot), 0);
    check("rst_rsp_valid", 32'(rsp_valid), 0);
    check("rst_rsp_rdata", rsp_rdata, 0);
    check("rst_rsp_err", 32'(rsp_err), 0);
    check("rst_rsp_timeout", 32'(rsp_timeout), 0);
    check("rst_cmd_ready", 32'(cmd_ready), 0);
    rst = 1'b0;
    chk_en = 1'b1;

    // zero-wait write
    run_txn(1'b1, 32'h10, 32'hDEADBEEF, 4'hF, 3'b000, 0, 0, 1'b0, 32'h0BADF00D, 0, 1'b0);
    check("wr_psel_at", 32'(obs_psel_first), 1);
    check("wr_pen_at", 32'(obs_pen_first), 2);
    check("wr_rsp_at", 32'(obs_rsp_first), 3);
    check("wr_rdata", obs_rdata, 32'h0);
    check("wr_err", 32'(obs_err), 0);

    // read with 3 wait states; pready lands on the timeout expiry cycle (TMO = 4)
    run_txn(1'b0, 32'h04, 32'h55555555, 4'hF, 3'b000, 1, 3, 1'b0, 32'h12345678, 0, 1'b0);
    check("rd3_pstrb", 32'(obs_pstrb), 0);
    check("rd3_rsp_at", 32'(obs_rsp_first), 6);
    check("rd3_rdata", obs_rdata, 32'h12345678);
    check("rd3_timeout", 32'(obs_tmo), 0);

    // completer error on the pready cycle
    run_txn(1'b0, 32'h08, 32'h0, 4'h0, 3'b000, 0, 2, 1'b1, 32'hCAFE0001, 0, 1'b0);
    check("slverr_err", 32'(obs_err), 1);
    check("slverr_timeout", 32'(obs_tmo), 0);

    // pslverr noise during waits must be ignored
    run_txn(1'b1, 32'h0C, 32'h01020304, 4'h3, 3'b000, 0, 3, 1'b0, 32'h0, 0, 1'b0);
    check("noise_err", 32'(obs_err), 0);
    check("noise_timeout", 32'(obs_tmo), 0);

    // timeout: pready never arrives
    run_txn(1'b0, 32'h30, 32'h0, 4'hF, 3'b000, 0, 1000, 1'b0, 32'hFFFFFFFF, 0, 1'b0);
    check("tmo_psel_drop", 32'(obs_psel_drop), 6);
    check("tmo_rsp_at", 32'(obs_rsp_first), 6);
    check("tmo_err", 32'(obs_err), 1);
    check("tmo_timeout", 32'(obs_tmo), 1);
    check("tmo_rdata", obs_rdata, 32'h0);

    // response backpressure with cmd_valid held high
    run_txn(1'b0, 32'h40, 32'h0, 4'h0, 3'b010, 0, 1, 1'b0, 32'h87654321, 5, 1'b1);
    check("bp_rsp_cycles", 32'(obs_rsp_cycles), 6);
    check("bp_cmd_ready_busy", 32'(obs_cr_busy), 0);
    check("bp_rdata", obs_rdata, 32'h87654321);

    // reset during ACCESS
    chk_en = 1'b0;
    pr_rst = '0;
    pr_rst[PPROT_PRIV]   = 1'b1;
    pr_rst[PPROT_NONSEC] = 1'b1;
    @(posedge clk); #1;
    cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 32'h20; cmd_wdata = 32'hA5A5A5A5;
    cmd_strb = 4'hF; cmd_prot = pr_rst; pready = 1'b0; rsp_ready = 1'b0;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    check("prerst_psel", 32'(psel), 1);
    check("prerst_pprot", 32'(pprot), 32'h3);
    @(posedge clk); #1;
    check("prerst_penable", 32'(penable), 1);
    rst = 1'b1;
    @(posedge clk); #1;
    check("midrst_psel", 32'(psel), 0);
    check("midrst_penable", 32'(penable), 0);
    check("midrst_pwrite", 32'(pwrite), 0);
    check("midrst_paddr", paddr, 0);
    check("midrst_pwdata", pwdata, 0);
    check("midrst_pstrb", 32'(pstrb), 0);
    check("midrst_pprot", 32'(pprot), 0);
    check("midrst_rsp_valid", 32'(rsp_valid), 0);
    check("midrst_rsp_err", 32'(rsp_err), 0);
    rst = 1'b0;
    pready = 1'b1;
    @(posedge clk); #1;
    check("postrst_cmd_ready", 32'(cmd_ready), 1);
    check("postrst_rsp_valid", 32'(rsp_valid), 0);
    check("postrst_psel", 32'(psel), 0);
    t_a = -100; t_e = 0; t_b = 0;
    chk_en = 1'b1;

    // randomized traffic
    for (int n = 0; n < 300; n++) begin
      run_txn(1'($urandom), $urandom, $urandom, SW'($urandom), 3'($urandom),
              $urandom_range(0, 2), $urandom_range(0, 6), 1'($urandom), $urandom,
              $urandom_range(0, 3), 1'($urandom));
    end
    @(posedge clk); #1;
    chk_en = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
